// File: rtl/jk_counter_pkg.sv
// Shared types and helpers for the JK-counter family.
package jk_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD  = 2'b00,
        JK_CLEAR = 2'b01,
        JK_MAX   = 2'b10,
        JK_COUNT = 2'b11
    } jk_mode_e;

    function automatic int unsigned jk_mod_max(int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_ff (
    input  logic jk_clk,
    input  logic jk_rs,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge jk_clk) begin
        if (jk_rs) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter built from JK flip-flops, with preset,
// saturating parallel load, terminal-count and registered wrap pulse.
module jk_mod_counter
    import jk_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             jk_clk,
    input  logic             jk_rs,
    input  logic             jk_set,
    input  logic             jk_load,
    input  logic [WIDTH-1:0] jk_d,
    input  logic             jk_j,
    input  logic             jk_k,
    input  logic             jk_up,
    output logic [WIDTH-1:0] jk_q,
    output logic             jk_tc,
    output logic             jk_wrap
);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
        $error("jk_mod_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
    end

    // One extra bit keeps MODULUS representable when MODULUS == 2**WIDTH.
    localparam int unsigned    MaxVal = jk_mod_max(MODULUS);
    localparam logic [WIDTH:0] MaxExt = (WIDTH + 1)'(MaxVal);
    localparam logic [WIDTH:0] ModExt = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   d_ext;
    logic             at_max;
    logic             at_zero;
    logic             wrap_nxt;
    logic             wrap_q;
    jk_mode_e         mode;

    assign cnt_ext = {1'b0, cnt};
    assign d_ext   = {1'b0, jk_d};
    assign at_max  = (cnt_ext == MaxExt);
    assign at_zero = (cnt_ext == '0);
    assign mode    = jk_mode_e'({jk_j, jk_k});

    always_comb begin
        nxt      = cnt;
        wrap_nxt = 1'b0;
        if (jk_rs) begin
            nxt = '0;
        end else if (jk_set) begin
            nxt = WIDTH'(MaxExt);
        end else if (jk_load) begin
            nxt = (d_ext < ModExt) ? jk_d : WIDTH'(MaxExt);
        end else begin
            unique case (mode)
                JK_HOLD:  nxt = cnt;
                JK_CLEAR: nxt = '0;
                JK_MAX:   nxt = WIDTH'(MaxExt);
                JK_COUNT: begin
                    if (jk_up) begin
                        if (at_max) begin
                            nxt      = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            nxt = WIDTH'(cnt_ext + 1'b1);
                        end
                    end else begin
                        if (at_zero) begin
                            nxt      = WIDTH'(MaxExt);
                            wrap_nxt = 1'b1;
                        end else begin
                            nxt = WIDTH'(cnt_ext - 1'b1);
                        end
                    end
                end
                default: nxt = cnt;
            endcase
        end
    end

    // Each bit's J/K are chosen so the flip-flop lands on the computed next value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff u_ff (
            .jk_clk (jk_clk),
            .jk_rs  (jk_rs),
            .j      (~cnt[i] & nxt[i]),
            .k      (cnt[i] & ~nxt[i]),
            .q      (cnt[i])
        );
    end

    always_ff @(posedge jk_clk) begin
        if (jk_rs) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_nxt;
        end
    end

    assign jk_q    = cnt;
    assign jk_wrap = wrap_q;
    assign jk_tc   = jk_j & jk_k & ~jk_set & ~jk_load & ~jk_rs & (jk_up ? at_max : at_zero);

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Parametrised successor to the team's fixed 4-bit JK counter: WIDTH-bit, modulo-MODULUS, up/down synchronous counter.
- Adds JK-style mode control, preset, parallel load, terminal-count and wrap flags.
- Used as a general event/divider counter in the JK-counter family. Instantiated standalone or cascaded via jk_tc.

Parameters:
WIDTH, 4, counter width in bits (>=1)
MODULUS, 2**WIDTH, count range 0..MODULUS-1. Elaboration error unless 2 <= MODULUS <= 2**WIDTH.

Ports:
jk_clk  input  1  clock, rising edge
jk_rs  input  1  reset, synchronous, active-high
jk_set  input  1  synchronous preset to MODULUS-1
jk_load  input  1  synchronous parallel load
jk_d  input  WIDTH  load value
jk_j  input  1  mode bit J
jk_k  input  1  mode bit K
jk_up  input  1  count direction: 1 = up, 0 = down
jk_q  output  WIDTH  counter value, registered
jk_tc  output  1  terminal count, combinational
jk_wrap  output  1  one-cycle wrap pulse, registered

Behaviour:
- One clock (jk_clk); reset jk_rs is synchronous and active-high.
- Reset values: jk_q = 0, jk_wrap = 0. jk_tc follows from jk_q and inputs.
- Per-edge priority, highest first: jk_rs > jk_set > jk_load > {jk_j,jk_k} mode.
- jk_rs=1: jk_q <= 0, jk_wrap <= 0. All other inputs are ignored. Reset mid-count takes effect at the next edge, with no partial update.
- jk_set=1: jk_q <= MODULUS-1, jk_wrap <= 0.
- jk_load=1:
  - jk_q <= jk_d when jk_d < MODULUS.
  - Otherwise jk_q <= MODULUS-1 (saturate, never out of range).
  - jk_wrap <= 0.
- Mode {jk_j,jk_k}, mirroring JK semantics:
  - 00 HOLD: jk_q unchanged.
  - 01 CLEAR: jk_q <= 0.
  - 10 MAX: jk_q <= MODULUS-1.
  - 11 COUNT: step by one in the direction of jk_up.
- COUNT up: jk_q == MODULUS-1 -> jk_q <= 0 and jk_wrap <= 1. Else jk_q+1.
- COUNT down: jk_q == 0 -> jk_q <= MODULUS-1 and jk_wrap <= 1. Else jk_q-1.
- Arithmetic is done in WIDTH+1 bits to avoid overflow when MODULUS = 2**WIDTH. Result is truncated to WIDTH after the modulus check.
- jk_wrap: 1 only in the cycle after a counting wrap. 0 after every other operation, including HOLD/CLEAR/MAX.
- jk_tc = (jk_j & jk_k & ~jk_set & ~jk_load & ~jk_rs) & (jk_up ? jk_q==MODULUS-1 : jk_q==0).
  - jk_tc is high exactly when the next edge will wrap.
  - For cascading: low stage jk_tc drives high stage jk_j/jk_k.
- Direction change mid-count takes effect on the same edge. There is no pipeline; latency from input to jk_q is 1 cycle.
- Power-up before the first reset: jk_q is undefined. The bench must assert jk_rs first.

Decomposition:
- Package jk_counter_pkg:
  - typedef enum logic [1:0] jk_mode_e {JK_HOLD=2'b00, JK_CLEAR=2'b01, JK_MAX=2'b10, JK_COUNT=2'b11}.
  - Helper function jk_mod_max(MODULUS) returning the MODULUS-1 constant.
- Sub-module jk_ff: single JK flip-flop, with ports jk_clk, jk_rs (sync, active-high), j, k, q.
  - The counter is WIDTH instances of jk_ff.
  - Per-bit J/K are derived from the next-state value: J = ~q & nxt, K = q & ~nxt.
- Top level holds next-state logic, saturation, jk_tc and the jk_wrap register.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset then count up: jk_rs=1 for 1 cycle, then j=k=1, up=1 for 12 cycles -> jk_q 0,1..9,0,1,2. jk_tc=1 while jk_q=9. jk_wrap=1 only in the cycle jk_q=0 after 9.
- Count down wrap: load jk_d=1, then j=k=1, up=0 -> jk_q 1,0,9,8. jk_tc=1 at jk_q=0. jk_wrap pulses with jk_q=9.
- Priority: jk_rs=1, jk_set=1, jk_load=1, jk_d=5, j=k=1 in the same cycle -> jk_q=0. Drop jk_rs -> jk_q=9 (set wins over load). Drop jk_set -> jk_q=5.
- Load saturation: jk_load=1, jk_d=13 -> jk_q=9, jk_wrap=0. HOLD for 3 cycles -> jk_q stays 9, jk_tc=0.
- JK modes from jk_q=4: {j,k}=01 -> 0; 10 -> 9; 00 -> 9 held; reset asserted in the middle of a count run -> jk_q=0 next edge, jk_wrap=0.
- Full-range variant WIDTH=4, MODULUS=16: count up from 14 -> 15, 0 (jk_wrap=1), 1. No overflow artefacts.
